// File: rtl/framebuffer_scheduler.sv
// Double-buffer controller: VGA reads the front bank while the back bank is cleared, then drawn.
// Banks swap only at a VGA frame boundary after the drawer reports the frame finished.

module fb_bank_port #(
  parameter int ADDR_WIDTH = 18
) (
  input  logic                  is_front,
  input  logic [ADDR_WIDTH-1:0] vga_addr,
  input  logic [ADDR_WIDTH-1:0] back_addr,
  input  logic                  back_we,
  input  logic                  back_wdata,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  we,
  output logic                  wdata
);
  // The front bank is read-only; the back bank takes clear/draw traffic.
  assign addr  = is_front ? vga_addr : back_addr;
  assign we    = ~is_front & back_we;
  assign wdata = ~is_front & back_wdata;
endmodule

module framebuffer_scheduler #(
  parameter int ADDR_WIDTH = 18,
  parameter int PIXELS     = 256000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] vga_read_addr,
  output logic                  vga_read_data,
  input  logic                  vga_swap,
  input  logic                  draw_valid,
  output logic                  draw_ready,
  input  logic [ADDR_WIDTH-1:0] draw_addr,
  input  logic                  draw_data,
  input  logic                  draw_done,
  output logic [ADDR_WIDTH-1:0] mem0_addr,
  output logic [ADDR_WIDTH-1:0] mem1_addr,
  output logic                  mem0_we,
  output logic                  mem1_we,
  output logic                  mem0_wdata,
  output logic                  mem1_wdata,
  input  logic                  mem0_rdata,
  input  logic                  mem1_rdata,
  output logic                  front,
  output logic                  clearing
);
  localparam logic [ADDR_WIDTH-1:0] LAST_PIX = ADDR_WIDTH'(PIXELS - 1);
  localparam logic [ADDR_WIDTH:0]   PIX_LIM  = (ADDR_WIDTH + 1)'(PIXELS);

  typedef enum logic [1:0] {CLEAR, DRAW, WAIT_SWAP} state_t;

  state_t                  state, state_next;
  logic                    front_next, front_q;
  logic [ADDR_WIDTH-1:0]   clr_cnt, clr_next;
  logic [ADDR_WIDTH-1:0]   back_addr;
  logic                    back_we, back_wdata, in_range;

  logic [1:0][ADDR_WIDTH-1:0] bank_addr;
  logic [1:0]                 bank_we, bank_wdata, bank_rdata;

  assign in_range = {1'b0, draw_addr} < PIX_LIM;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= CLEAR;
      front   <= 1'b0;
      front_q <= 1'b0;
      clr_cnt <= '0;
    end else begin
      state   <= state_next;
      front   <= front_next;
      front_q <= front;
      clr_cnt <= clr_next;
    end
  end

  always_comb begin
    state_next = state;
    front_next = front;
    clr_next   = clr_cnt;
    back_addr  = clr_cnt;
    back_we    = 1'b0;
    back_wdata = 1'b0;
    case (state)
      CLEAR: begin
        back_we = 1'b1;
        if (clr_cnt == LAST_PIX) begin
          clr_next   = '0;
          state_next = DRAW;
        end else begin
          clr_next = clr_cnt + 1'b1;
        end
      end
      DRAW: begin
        // Out-of-range pixels are still handshaken, just never written.
        back_addr  = draw_addr;
        back_wdata = draw_data;
        back_we    = draw_valid & in_range;
        if (draw_done) state_next = WAIT_SWAP;
      end
      WAIT_SWAP: begin
        if (vga_swap) begin
          front_next = ~front;
          clr_next   = '0;
          state_next = CLEAR;
        end
      end
      default: state_next = CLEAR;
    endcase
  end

  assign draw_ready = (state == DRAW);
  assign clearing   = (state == CLEAR);

  for (genvar b = 0; b < 2; b++) begin : g_bank
    localparam logic IDX = 1'(b);
    fb_bank_port #(.ADDR_WIDTH(ADDR_WIDTH)) u_port (
      .is_front  (front == IDX),
      .vga_addr  (vga_read_addr),
      .back_addr (back_addr),
      .back_we   (back_we),
      .back_wdata(back_wdata),
      .addr      (bank_addr[b]),
      .we        (bank_we[b]),
      .wdata     (bank_wdata[b])
    );
  end

  assign mem0_addr  = bank_addr[0];
  assign mem1_addr  = bank_addr[1];
  assign mem0_we    = bank_we[0];
  assign mem1_we    = bank_we[1];
  assign mem0_wdata = bank_wdata[0];
  assign mem1_wdata = bank_wdata[1];
  assign bank_rdata = {mem1_rdata, mem0_rdata};

  // Read data follows the bank that was front when the address was issued.
  assign vga_read_data = bank_rdata[front_q];
endmodule

// File: tb/tb_framebuffer_scheduler.sv
// Directed bench for framebuffer_scheduler with PIXELS=16 and two behavioural 1-bit RAM banks.

module tb_framebuffer_scheduler;
  localparam int AW = 18;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] vga_read_addr;
  logic          vga_read_data;
  logic          vga_swap;
  logic          draw_valid, draw_ready;
  logic [AW-1:0] draw_addr;
  logic          draw_data, draw_done;
  logic [AW-1:0] mem0_addr, mem1_addr;
  logic          mem0_we, mem1_we, mem0_wdata, mem1_wdata;
  logic          mem0_rdata, mem1_rdata;
  logic          front, clearing;

  int tests = 0;
  int fails = 0;
  int wr0 = 0;
  int wr1 = 0;

  logic m0 [0:63];
  logic m1 [0:63];

  framebuffer_scheduler #(.ADDR_WIDTH(AW), .PIXELS(16)) dut (
    .clk(clk), .rst(rst),
    .vga_read_addr(vga_read_addr), .vga_read_data(vga_read_data), .vga_swap(vga_swap),
    .draw_valid(draw_valid), .draw_ready(draw_ready), .draw_addr(draw_addr),
    .draw_data(draw_data), .draw_done(draw_done),
    .mem0_addr(mem0_addr), .mem1_addr(mem1_addr), .mem0_we(mem0_we), .mem1_we(mem1_we),
    .mem0_wdata(mem0_wdata), .mem1_wdata(mem1_wdata),
    .mem0_rdata(mem0_rdata), .mem1_rdata(mem1_rdata),
    .front(front), .clearing(clearing)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem0_we) begin m0[mem0_addr[5:0]] <= mem0_wdata; wr0 <= wr0 + 1; end
    if (mem1_we) begin m1[mem1_addr[5:0]] <= mem1_wdata; wr1 <= wr1 + 1; end
    mem0_rdata <= m0[mem0_addr[5:0]];
    mem1_rdata <= m1[mem1_addr[5:0]];
  end

  task automatic step();
    @(negedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; vga_read_addr = 18'd3; vga_swap = 0;
    draw_valid = 0; draw_addr = '0; draw_data = 0; draw_done = 0;
    repeat (2) @(negedge clk);
    #1;
    tests++; if (front !== 1'b0)    begin fails++; $display("FAIL reset_front got %0b want 0", front); end
    tests++; if (clearing !== 1'b1) begin fails++; $display("FAIL reset_clearing got %0b want 1", clearing); end
    tests++; if (draw_ready !== 1'b0) begin fails++; $display("FAIL reset_ready got %0b want 0", draw_ready); end
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tests++; if (front !== 1'b0) begin fails++; $display("FAIL clr1_front cyc %0d got %0b want 0", i, front); end
      tests++; if (mem0_addr !== 18'd3 || mem0_we !== 1'b0) begin
        fails++; $display("FAIL clr1_front_port cyc %0d got addr %0d we %0b want 3/0", i, mem0_addr, mem0_we);
      end
      if (i < 16) begin
        tests++; if (mem1_we !== 1'b1 || mem1_addr !== AW'(i) || mem1_wdata !== 1'b0) begin
          fails++; $display("FAIL clr1_write cyc %0d got we %0b addr %0d wd %0b want 1/%0d/0", i, mem1_we, mem1_addr, mem1_wdata, i);
        end
        tests++; if (draw_ready !== 1'b0 || clearing !== 1'b1) begin
          fails++; $display("FAIL clr1_flags cyc %0d got ready %0b clearing %0b want 0/1", i, draw_ready, clearing);
        end
      end else begin
        tests++; if (draw_ready !== 1'b1 || clearing !== 1'b0) begin
          fails++; $display("FAIL clr1_done cyc %0d got ready %0b clearing %0b want 1/0", i, draw_ready, clearing);
        end
      end
      step();
    end
  endtask

  task automatic test_draw();
    int base;
    base = wr1;
    draw_valid = 1; draw_addr = 18'd5; draw_data = 1; #1;
    tests++; if (draw_ready !== 1'b1 || mem1_we !== 1'b1 || mem1_addr !== 18'd5 || mem1_wdata !== 1'b1) begin
      fails++; $display("FAIL draw_in_range got rdy %0b we %0b addr %0d wd %0b want 1/1/5/1", draw_ready, mem1_we, mem1_addr, mem1_wdata);
    end
    step();
    draw_addr = 18'd20; #1;
    tests++; if (draw_ready !== 1'b1 || mem1_we !== 1'b0) begin
      fails++; $display("FAIL draw_out_of_range got rdy %0b we %0b want 1/0", draw_ready, mem1_we);
    end
    step();
    draw_valid = 0; draw_done = 1; #1;
    tests++; if (mem1_we !== 1'b0) begin fails++; $display("FAIL draw_done_idle_we got %0b want 0", mem1_we); end
    step();
    draw_done = 0; draw_valid = 1; draw_addr = 18'd6; #1;
    tests++; if (draw_ready !== 1'b0 || clearing !== 1'b0 || mem1_we !== 1'b0) begin
      fails++; $display("FAIL wait_swap_hold got rdy %0b clr %0b we %0b want 0/0/0", draw_ready, clearing, mem1_we);
    end
    step();
    draw_valid = 0;
    tests++; if (wr1 - base !== 1) begin fails++; $display("FAIL draw_write_count got %0d want 1", wr1 - base); end
    tests++; if (m1[5] !== 1'b1 || m1[6] !== 1'b0) begin
      fails++; $display("FAIL draw_bank1_content got m1[5]=%0b m1[6]=%0b want 1/0", m1[5], m1[6]);
    end
  endtask

  task automatic test_swap();
    vga_read_addr = 18'd5; vga_swap = 1; #1;
    tests++; if (front !== 1'b0 || mem0_addr !== 18'd5) begin
      fails++; $display("FAIL swap_pre got front %0b addr0 %0d want 0/5", front, mem0_addr);
    end
    step();
    vga_swap = 0; #1;
    for (int i = 0; i < 16; i++) begin
      tests++; if (front !== 1'b1 || clearing !== 1'b1) begin
        fails++; $display("FAIL swap_front cyc %0d got front %0b clr %0b want 1/1", i, front, clearing);
      end
      tests++; if (mem0_we !== 1'b1 || mem0_addr !== AW'(i) || mem0_wdata !== 1'b0 || mem1_we !== 1'b0 || mem1_addr !== 18'd5) begin
        fails++; $display("FAIL clr0_write cyc %0d got we0 %0b a0 %0d wd0 %0b we1 %0b a1 %0d want 1/%0d/0/0/5",
                          i, mem0_we, mem0_addr, mem0_wdata, mem1_we, mem1_addr, i);
      end
      if (i == 1) begin
        tests++; if (vga_read_data !== 1'b1) begin fails++; $display("FAIL swap_read_data got %0b want 1", vga_read_data); end
      end
      step();
    end
    tests++; if (draw_ready !== 1'b1 || clearing !== 1'b0) begin
      fails++; $display("FAIL clr0_done got rdy %0b clr %0b want 1/0", draw_ready, clearing);
    end
  endtask

  task automatic test_swap_in_draw();
    vga_swap = 1; step();
    vga_swap = 0; #1;
    tests++; if (front !== 1'b1 || draw_ready !== 1'b1 || clearing !== 1'b0) begin
      fails++; $display("FAIL swap_in_draw got front %0b rdy %0b clr %0b want 1/1/0", front, draw_ready, clearing);
    end
  endtask

  task automatic test_done_and_swap();
    draw_valid = 1; draw_addr = 18'd3; draw_data = 1; draw_done = 1; vga_swap = 1; #1;
    tests++; if (mem0_we !== 1'b1 || mem0_addr !== 18'd3) begin
      fails++; $display("FAIL done_write got we %0b addr %0d want 1/3", mem0_we, mem0_addr);
    end
    step();
    draw_valid = 0; draw_done = 0; vga_swap = 0; #1;
    tests++; if (front !== 1'b1 || draw_ready !== 1'b0 || clearing !== 1'b0) begin
      fails++; $display("FAIL done_swap_same got front %0b rdy %0b clr %0b want 1/0/0", front, draw_ready, clearing);
    end
    tests++; if (m0[3] !== 1'b1) begin fails++; $display("FAIL done_write_content got %0b want 1", m0[3]); end
    step();
    tests++; if (front !== 1'b1 || draw_ready !== 1'b0) begin
      fails++; $display("FAIL wait_idle got front %0b rdy %0b want 1/0", front, draw_ready);
    end
    vga_swap = 1; step();
    vga_swap = 0; #1;
    tests++; if (front !== 1'b0 || clearing !== 1'b1 || mem1_we !== 1'b1 || mem1_addr !== 18'd0) begin
      fails++; $display("FAIL next_swap got front %0b clr %0b we1 %0b a1 %0d want 0/1/1/0", front, clearing, mem1_we, mem1_addr);
    end
  endtask

  task automatic test_swap_in_clear();
    int n;
    step(); step();
    vga_swap = 1; #1;
    tests++; if (mem1_addr !== 18'd2) begin fails++; $display("FAIL clear_pos got %0d want 2", mem1_addr); end
    step();
    vga_swap = 0; #1;
    tests++; if (front !== 1'b0 || clearing !== 1'b1 || mem1_addr !== 18'd3) begin
      fails++; $display("FAIL swap_in_clear got front %0b clr %0b a1 %0d want 0/1/3", front, clearing, mem1_addr);
    end
    n = 0;
    while (!draw_ready && n < 40) begin step(); n++; end
    tests++; if (n !== 13) begin fails++; $display("FAIL clear_remaining got %0d cycles want 13", n); end
  endtask

  task automatic test_reset_mid();
    draw_done = 1; step();
    draw_done = 0; vga_swap = 1; step();
    vga_swap = 0; #1;
    tests++; if (front !== 1'b1 || mem0_addr !== 18'd0 || mem0_we !== 1'b1) begin
      fails++; $display("FAIL pre_reset_swap got front %0b a0 %0d we0 %0b want 1/0/1", front, mem0_addr, mem0_we);
    end
    repeat (7) step();
    tests++; if (mem0_addr !== 18'd7) begin fails++; $display("FAIL pre_reset_cnt got %0d want 7", mem0_addr); end
    rst = 1; #1;
    tests++; if (front !== 1'b0 || clearing !== 1'b1 || draw_ready !== 1'b0) begin
      fails++; $display("FAIL mid_reset got front %0b clr %0b rdy %0b want 0/1/0", front, clearing, draw_ready);
    end
    tests++; if (mem1_we !== 1'b1 || mem1_addr !== 18'd0 || mem0_we !== 1'b0) begin
      fails++; $display("FAIL mid_reset_ports got we1 %0b a1 %0d we0 %0b want 1/0/0", mem1_we, mem1_addr, mem0_we);
    end
    step();
    rst = 0; #1;
    for (int i = 0; i < 4; i++) begin
      tests++; if (mem1_we !== 1'b1 || mem1_addr !== AW'(i) || front !== 1'b0) begin
        fails++; $display("FAIL restart_clear cyc %0d got we1 %0b a1 %0d front %0b want 1/%0d/0", i, mem1_we, mem1_addr, front, i);
      end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_draw();
    test_swap();
    test_swap_in_draw();
    test_done_and_swap();
    test_swap_in_clear();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
